pc_seq_ctrl: RTL and testbench

Fetch sequencer for the 3-stage pipeline's program counter. Drives the counter's increment (`ipc`) and load (`lpc`) strobes, the load value, and the pipeline flush. It resolves run/halt, hazard stalls and taken branches into exactly one PC action per cycle, and never asserts `ipc` and `lpc` together.

---
 rtl/pc_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
// Fetch sequencer for the program counter of the 3-stage pipeline.
// Each cycle it resolves run/halt, hazard stalls and taken branches into
// one PC action: increment, load, or hold. Increment and load are never
// strobed in the same cycle.
//
// Optional feature macro: PCSEQ_BRCNT_EN
//   defined   - br_count counts accepted branches and saturates at 16'hFFFF
//   undefined - no counter register, br_count is tied to zero
//
// Ports
//   clk          in   rising-edge clock
//   clear        in   asynchronous active-high reset
//   run          in   start / resume request (a rising edge leaves HALT)
//   stall        in   datapath hazard, hold the PC this cycle
//   br_req       in   taken branch resolved this cycle
//   br_target    in   [N] branch destination, valid with br_req
//   halt_req     in   HALT instruction decoded
//   ipc          out  PC increment strobe
//   lpc          out  PC load strobe
//   pc_load_val  out  [N] value for the PC load port (zero unless lpc)
//   flush        out  kill the instructions in fetch and decode
//   fetch_valid  out  the instruction fetched this cycle is valid
//   state        out  [2] current FSM state, for debug
//   br_count     out  [16] taken-branch count
module pc_seq_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         run,
    input  logic         stall,
    input  logic         br_req,
    input  logic [N-1:0] br_target,
    input  logic         halt_req,
    output logic         ipc,
    output logic         lpc,
    output logic [N-1:0] pc_load_val,
    output logic         flush,
    output logic         fetch_valid,
    output logic [1:0]   state,
    output logic [15:0]  br_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FETCH    = 2'b01,
        REDIRECT = 2'b10,
        HALT     = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   run_q;

    // State register plus the previous value of run, used to detect the
    // rising edge of run that is the only way out of HALT.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run;
        end
    end

    // Next-state and strobe decode. In FETCH a branch beats a halt, which
    // beats a stall; REDIRECT is a one-cycle bubble that ignores all
    // requests while the target is read.
    always_comb begin
        state_d     = state_q;
        ipc         = 1'b0;
        lpc         = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        pc_load_val = '0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (br_req) begin
                    lpc         = 1'b1;
                    flush       = 1'b1;
                    pc_load_val = br_target;
                    state_d     = REDIRECT;
                end else if (halt_req) begin
                    flush   = 1'b1;
                    state_d = HALT;
                end else if (!stall) begin
                    ipc         = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            REDIRECT: begin
                flush   = 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                if (run && !run_q) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

`ifdef PCSEQ_BRCNT_EN
    logic        br_taken;
    logic [15:0] br_cnt_q;

    assign br_taken = (state_q == FETCH) && br_req;

    // Saturating count of accepted branches; only clear resets it.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            br_cnt_q <= 16'h0000;
        end else if (br_taken && (br_cnt_q != 16'hFFFF)) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign br_count = br_cnt_q;
`else
    assign br_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl
// Self-checking bench for pc_seq_ctrl with an attached program counter.
// A table of vectors covers the basic state walk, hand sequences cover the
// multi-cycle corners, and a random run is checked against a reference model.
module tb_pc_seq_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clear;
    logic         run;
    logic         stall;
    logic         br_req;
    logic [N-1:0] br_target;
    logic         halt_req;
    logic         ipc;
    logic         lpc;
    logic [N-1:0] pc_load_val;
    logic         flush;
    logic         fetch_valid;
    logic [1:0]   state;
    logic [15:0]  br_count;

    logic [N-1:0] pc;

    int n_cmp = 0;
    int n_err = 0;

    pc_seq_ctrl #(.N(N)) dut (
        .clk(clk), .clear(clear), .run(run), .stall(stall),
        .br_req(br_req), .br_target(br_target), .halt_req(halt_req),
        .ipc(ipc), .lpc(lpc), .pc_load_val(pc_load_val), .flush(flush),
        .fetch_valid(fetch_valid), .state(state), .br_count(br_count)
    );

    always #5 clk = ~clk;

    // Program counter driven by the DUT strobes.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) pc <= '0;
        else if (lpc) pc <= pc_load_val;
        else if (ipc) pc <= pc + 8'd1;
    end

    // Reference model: mode names follow the debug state values.
    localparam int M_IDLE = 0, M_FETCH = 1, M_BUBBLE = 2, M_HALT = 3;
    int           m_mode;
    logic         m_prev_run;
    int           m_branches;
    logic [N-1:0] m_pc;
    int           m_next;
    logic         e_ipc, e_lpc, e_flush, e_fv;
    logic [N-1:0] e_plv;

    task automatic model_eval();
        e_ipc = 0; e_lpc = 0; e_flush = 0; e_fv = 0; e_plv = '0;
        m_next = m_mode;
        if (m_mode == M_IDLE) begin
            if (run) m_next = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (br_req) begin
                e_lpc = 1; e_flush = 1; e_plv = br_target; m_next = M_BUBBLE;
            end else if (halt_req) begin
                e_flush = 1; m_next = M_HALT;
            end else if (!stall) begin
                e_ipc = 1; e_fv = 1;
            end
        end else if (m_mode == M_BUBBLE) begin
            e_flush = 1; m_next = M_FETCH;
        end else begin
            if (run && !m_prev_run) m_next = M_FETCH;
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef PCSEQ_BRCNT_EN
        return (m_branches > 16'hFFFF) ? 16'hFFFF : 16'(m_branches);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares DUT outputs and attached PC with the model for this cycle.
    task automatic check_output();
        model_eval();
        check_val("outputs", {2'b0, ipc, lpc, flush, fetch_valid, state, pc_load_val, br_count},
                  {2'b0, e_ipc, e_lpc, e_flush, e_fv, 2'(m_mode), e_plv, exp_count()});
        check_val("pc", 32'(pc), 32'(m_pc));
        check_val("no_ipc_and_lpc", 32'(ipc & lpc), 32'd0);
    endtask

    // Drives inputs at +1 after an edge, then checks at +3.
    task automatic apply_stimulus(input logic r, input logic s, input logic b,
                                  input logic h, input logic [N-1:0] t);
        run = r; stall = s; br_req = b; halt_req = h; br_target = t;
        #2;
        check_output();
    endtask

    task automatic tick();
        model_eval();
        if (m_mode == M_FETCH && br_req) m_branches++;
        if (e_lpc) m_pc = e_plv;
        else if (e_ipc) m_pc = m_pc + 8'd1;
        m_prev_run = run;
        m_mode = m_next;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1; run = 0; stall = 0; br_req = 0; halt_req = 0; br_target = '0;
        m_mode = M_IDLE; m_prev_run = 0; m_branches = 0; m_pc = '0;
        #3;
        check_val("reset_outputs", {ipc, lpc, flush, fetch_valid, state, pc_load_val, br_count}, '0);
        @(posedge clk);
        #1;
        clear = 0;
    endtask

    task automatic step(input logic r, input logic s, input logic b,
                        input logic h, input logic [N-1:0] t);
        apply_stimulus(r, s, b, h, t);
        tick();
    endtask

    typedef struct {
        logic         run, stall, br, halt;
        logic [N-1:0] target;
        logic         x_ipc, x_lpc, x_flush, x_fv;
        logic [1:0]   x_state;
        logic [N-1:0] x_plv;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0,0,0,0,8'h00, 0,0,0,0,2'd0,8'h00};
        vecs[1] = '{1,0,0,0,8'h00, 0,0,0,0,2'd0,8'h00};
        vecs[2] = '{0,0,0,0,8'hAA, 1,0,0,1,2'd1,8'h00};
        vecs[3] = '{0,0,1,0,8'h40, 0,1,1,0,2'd1,8'h40};
        vecs[4] = '{0,1,1,1,8'h11, 0,0,1,0,2'd2,8'h00};
        vecs[5] = '{0,0,0,0,8'h00, 1,0,0,1,2'd1,8'h00};
        vecs[6] = '{0,1,0,0,8'h00, 0,0,0,0,2'd1,8'h00};
        vecs[7] = '{0,1,0,1,8'h00, 0,0,1,0,2'd1,8'h00};
        vecs[8] = '{1,0,0,0,8'h00, 0,0,0,0,2'd3,8'h00};
        vecs[9] = '{1,0,0,0,8'h00, 1,0,0,1,2'd1,8'h00};

        // Table walk: idle, start, branch, bubble, stall, halt, restart.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].run, vecs[i].stall, vecs[i].br, vecs[i].halt, vecs[i].target);
            check_val($sformatf("vec%0d", i),
                      {ipc, lpc, flush, fetch_valid, state, pc_load_val},
                      {vecs[i].x_ipc, vecs[i].x_lpc, vecs[i].x_flush, vecs[i].x_fv,
                       vecs[i].x_state, vecs[i].x_plv});
            tick();
        end

        // Start-up: PC reads 0,1,2,3 on successive edges.
        do_reset();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("startup_pc", 32'(pc), 32'(i));
            step(1, 0, 0, 0, 0);
        end

        // Branch to 8'h40: bubble, then fetch target, then 8'h41.
        step(1, 0, 1, 0, 8'h40);
        check_val("br_pc_loaded", 32'(pc), 32'h40);
        apply_stimulus(1, 0, 0, 0, 0);
        check_val("br_bubble", {state, flush, ipc}, {2'd2, 1'b1, 1'b0});
        tick();
        apply_stimulus(1, 0, 0, 0, 0);
        check_val("br_target_fetch", {ipc, fetch_valid}, 2'b11);
        tick();
        check_val("br_pc_next", 32'(pc), 32'h41);

        // Branch + halt + stall together: branch wins, counter advances.
        do_reset();
        step(1, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 1, 8'h5C);
        check_val("all_req_plv", 32'(pc_load_val), 32'h5C);
        tick();
        check_val("all_req_no_halt", 32'(state), 32'd2);
`ifdef PCSEQ_BRCNT_EN
        check_val("all_req_count", 32'(br_count), 32'd1);
`else
        check_val("all_req_count", 32'(br_count), 32'd0);
`endif

        // Halt with run held high: stays halted until a fresh run edge.
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 0, 0, 0, 0);
            check_val("halt_hold", {state, ipc}, {2'd3, 1'b0});
            tick();
        end
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_val("halt_restart", 32'(state), 32'd1);

        // Stall three cycles at PC 8'h05.
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && pc != 8'h05; i++) step(1, 0, 0, 0, 0);
        check_val("stall_reach_pc5", 32'(pc), 32'h05);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 0, 0, 0);
            check_val("stall_fv", 32'(fetch_valid), 32'd0);
            tick();
            check_val("stall_pc_hold", 32'(pc), 32'h05);
        end
        step(1, 0, 0, 0, 0);
        check_val("stall_resume", 32'(pc), 32'h06);

        // Asynchronous clear in REDIRECT aborts at once.
        step(1, 0, 1, 0, 8'h22);
        apply_stimulus(1, 0, 0, 0, 0);
        clear = 1;
        #1;
        check_val("clear_in_redirect",
                  {ipc, lpc, flush, fetch_valid, state, pc_load_val, br_count, pc}, '0);
        @(posedge clk);
        #1;
        check_val("clear_holds_idle", 32'(state), 32'd0);
        clear = 0;
        run = 0;
        m_mode = M_IDLE; m_prev_run = 0; m_branches = 0; m_pc = '0;

        // Random run against the model.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
